// File: rtl/encoder_acq_sched_pkg.sv
// rtl/encoder_acq_sched_pkg.sv - shared mode, state and error-bit definitions for the acquisition scheduler
package encoder_acq_sched_pkg;

  typedef enum logic [2:0] {
    MODE_SINCOS = 3'd0,
    MODE_ABZ    = 3'd1,
    MODE_BISS   = 3'd2,
    MODE_SSI    = 3'd3,
    MODE_TAWA   = 3'd4,
    MODE_ENDAT  = 3'd5
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_PUSH      = 3'd3,
    ST_SWITCH    = 3'd4
  } acq_state_t;

  localparam int unsigned ERR_ENG = 0;
  localparam int unsigned ERR_TMO = 1;

endpackage

// File: rtl/encoder_acq_sched_tick_gen.sv
// rtl/encoder_acq_sched_tick_gen.sv - programmable sample tick, one pulse every period+1 clocks
module encoder_acq_sched_tick_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_q;

  // per_q only follows period at a wrap (or while stopped) so a change never truncates a running interval
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      per_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (per_q == '0) begin
        cnt   <= '0;
        per_q <= period;
      end else if (cnt == per_q) begin
        cnt   <= '0;
        per_q <= period;
        tick  <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_acq_sched.sv
// rtl/encoder_acq_sched.sv - triggers the active encoder engine per tick, waits for done/timeout, registers the sample
module encoder_acq_sched
  import encoder_acq_sched_pkg::*;
#(
  parameter int NUM_PROTO = 6,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int GUARD_CYC = 64,
  parameter int IDX_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CNT_W-1:0]            period,
  input  logic [CNT_W-1:0]            timeout,
  input  logic [IDX_W-1:0]            mode_sel,
  output logic [NUM_PROTO-1:0]        eng_req,
  input  logic [NUM_PROTO-1:0]        eng_done,
  input  logic [NUM_PROTO-1:0]        eng_err,
  input  logic [NUM_PROTO*DATA_W-1:0] eng_data,
  output logic                        drv_en,
  output logic [IDX_W-1:0]            act_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [1:0]                  out_err,
  output logic [15:0]                 overrun_cnt,
  output logic                        busy
);

  localparam int GW = $clog2(GUARD_CYC + 1);

  acq_state_t       state;
  logic             tick;
  logic [CNT_W-1:0] tmo_cnt;
  logic [GW-1:0]    guard_cnt;
  logic [IDX_W-1:0] sw_target;
  logic [1:0]       init_cnt;
  logic             err_cap;
  logic             tmo_cap;

  logic [DATA_W-1:0]    mux_data;
  logic                 done_act;
  logic                 err_act;
  logic [NUM_PROTO-1:0] req_vec;
  logic                 init_done;
  logic                 mode_chg;
  logic                 tmo_hit;
  logic                 tick_drop;
  logic                 push_ovr;

  encoder_acq_sched_tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    mux_data = '0;
    done_act = 1'b0;
    err_act  = 1'b0;
    req_vec  = '0;
    for (int i = 0; i < NUM_PROTO; i++) begin
      if (act_mode == IDX_W'(i)) begin
        mux_data   = eng_data[i*DATA_W +: DATA_W];
        done_act   = eng_done[i];
        err_act    = eng_err[i];
        req_vec[i] = 1'b1;
      end
    end
  end

  assign init_done = (init_cnt == 2'd2);
  assign mode_chg  = (mode_sel != act_mode);
  assign tmo_hit   = (timeout != '0) && (tmo_cnt == timeout - 1'b1);
  // ticks during the post-reset holdoff are not overruns; IDLE about to switch is
  assign tick_drop = tick && ((state != ST_IDLE) || (init_done && mode_chg));
  assign push_ovr  = (state == ST_PUSH) && out_valid && !out_ready;
  assign busy      = (state == ST_REQ) || (state == ST_WAIT_DONE) || (state == ST_SWITCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      eng_req     <= '0;
      drv_en      <= 1'b0;
      act_mode    <= IDX_W'(MODE_SINCOS);
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= '0;
      overrun_cnt <= '0;
      tmo_cnt     <= '0;
      guard_cnt   <= '0;
      sw_target   <= '0;
      init_cnt    <= '0;
      err_cap     <= 1'b0;
      tmo_cap     <= 1'b0;
    end else begin
      eng_req <= '0;

      if (!init_done) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == 2'd1 && !mode_chg) drv_en <= 1'b1;
      end

      if ((tick_drop || push_ovr) && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 1'b1;

      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (init_done) begin
            if (mode_chg) begin
              state     <= ST_SWITCH;
              drv_en    <= 1'b0;
              guard_cnt <= '0;
              sw_target <= mode_sel;
            end else if (tick) begin
              eng_req <= req_vec;
              state   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done_act) begin
            err_cap <= err_act;
            tmo_cap <= 1'b0;
            state   <= ST_PUSH;
          end else if (tmo_hit) begin
            err_cap <= 1'b0;
            tmo_cap <= 1'b1;
            state   <= ST_PUSH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_PUSH: begin
          out_valid        <= 1'b1;
          out_err[ERR_TMO] <= tmo_cap;
          out_err[ERR_ENG] <= err_cap;
          if (!tmo_cap) out_data <= mux_data;
          state <= ST_IDLE;
        end
        ST_SWITCH: begin
          // a fresh request restarts the guard so the drivers see a full quiet interval
          if (mode_sel != sw_target) begin
            sw_target <= mode_sel;
            guard_cnt <= '0;
          end else if (guard_cnt == GW'(GUARD_CYC - 1)) begin
            act_mode <= sw_target;
            drv_en   <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
